memory_arbiter: RTL
===================

# memory_arbiter

RAM-side responder for the icache and dcache request interfaces. Accepts instruction reads and data reads/writes, arbitrates between them, and issues one registered transaction at a time to the shared RAM. It holds each requester in wait until the RAM reports ACCESS, then returns read data. Sits between the two caches and the RAM model, completing the cache request protocol from the memory end.

## Interface
- STARVE_LIMIT, 4: consecutive dcache grants allowed while iREN is pending before icache must be granted (1..15).
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  icache read request, held until iwait low.
- iaddr  in  32  icache word address.
- iwait  out  1  high while the icache request is not yet satisfied.
- iload  out  32  instruction returned to icache.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; never asserted together with dREN.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  high while the dcache request is not yet satisfied.
- dload  out  32  data returned to dcache.
- ramREN  out  1  RAM read enable (registered).
- ramWEN  out  1  RAM write enable (registered).
- ramaddr  out  32  RAM address (registered).
- ramstore  out  32  RAM write data (registered).
- ramload  in  32  RAM read data, valid when ramstate is ACCESS.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memerr  out  1  one-cycle pulse when a transaction ends in ERROR.

## Operation
- States: IDLE, IGNT, DGNT.
- IDLE: if data request (dREN|dWEN) and not starved -> DGNT; else if iREN -> IGNT; else stay. Starved = iREN high and starve_cnt == STARVE_LIMIT; starved selects IGNT even with a data request pending.
- On entering a grant state, ramREN/ramWEN/ramaddr/ramstore are loaded from the granted requester in the same clock edge; held constant for the whole grant.
- IGNT/DGNT: ramstate ACCESS -> granted wait driven low and load output = ramload, combinationally in that cycle; next state IDLE, RAM enables cleared.
- ramstate ERROR -> wait driven low, load output = 0, memerr high that cycle; next state IDLE.
- FREE/BUSY -> stay; wait stays high.
- Requester drops its request while granted (DGNT with dREN=dWEN=0, or IGNT with iREN=0) -> abort: next state IDLE, enables cleared, no completion or memerr.
- starve_cnt (4 bits): increments on each DGNT completion while iREN is high; clears on any IGNT completion or when iREN is low in IDLE; saturates at STARVE_LIMIT.
- Ungranted requester: its wait output is high whenever its request is asserted; its load output is 0.
- Write completion: dload = 0.

## Timing
- Reset values: state IDLE, starve_cnt 0, ramREN 0, ramWEN 0, ramaddr 0, ramstore 0, memerr 0, iload 0, dload 0. iwait = iREN and dwait = dREN|dWEN, since neither requester is granted.
- Minimum latency: request seen in IDLE at cycle n; RAM enables visible at n+1; ACCESS at n+1 completes at n+1 (2 cycles, wait low in cycle n+1).
- Back-to-back transactions have one IDLE cycle between grants; RAM enables are low in that cycle.
- Simultaneous i and d requests in IDLE: d wins unless starved. Loser is served on the next IDLE.
- Reset mid-transaction: all outputs return to reset values immediately; no completion is reported.

## Test plan
- Single ifetch: iREN=1, iaddr=0x40, RAM ACCESS after 3 BUSY cycles, ramload=0xDEADBEEF -> ramREN high from cycle 1; iwait low only in cycle 4 with iload=0xDEADBEEF; IDLE in cycle 5.
- Write: dWEN=1, daddr=0x80, dstore=0x12345678, immediate ACCESS -> ramWEN=1, ramaddr=0x80, ramstore=0x12345678 in cycle 1; dwait low in cycle 1.
- Contention: iREN and dREN both high at cycle 0, 1-cycle RAM -> DGNT first, IGNT second; iwait stays high until the second completion.
- Starvation: iREN held, dREN held continuously, STARVE_LIMIT=4 -> exactly 4 data completions, then an icache grant, then starve_cnt = 0.
- Error: dREN with ramstate=ERROR -> memerr pulse for 1 cycle, dload=0, dwait low that cycle, back to IDLE.
- Abort and reset: iREN dropped while RAM is BUSY -> ramREN low next cycle, no completion. nRST asserted in DGNT -> ramREN/ramWEN drop to 0 asynchronously.

Source files
------------

// File: rtl/memory_arbiter.sv
// RAM-side arbiter for the icache and dcache request ports. It issues one registered RAM
// transaction at a time, holds each requester's wait until the RAM answers, and stops dcache from starving icache.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IGNT = 2'd1;
  localparam logic [1:0] DGNT = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        ram_ren_q, ram_ren_d;
  logic        ram_wen_q, ram_wen_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_store_q, ram_store_d;

  logic data_req;
  logic starved;
  logic ram_done;
  logic i_active;
  logic d_active;

  always_comb begin
    data_req = dREN | dWEN;
    starved  = iREN && (starve_cnt_q == LIMIT);
    ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
    // A grant whose requester has dropped its request is an abort, not a completion.
    i_active = (state_q == IGNT) && iREN;
    d_active = (state_q == DGNT) && data_req;
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    ram_ren_d    = ram_ren_q;
    ram_wen_d    = ram_wen_q;
    ram_addr_d   = ram_addr_q;
    ram_store_d  = ram_store_q;
    case (state_q)
      IDLE: begin
        if (!iREN) starve_cnt_d = 4'd0;
        if (data_req && !starved) begin
          state_d     = DGNT;
          ram_ren_d   = dREN;
          ram_wen_d   = dWEN;
          ram_addr_d  = daddr;
          ram_store_d = dstore;
        end else if (iREN) begin
          state_d     = IGNT;
          ram_ren_d   = 1'b1;
          ram_wen_d   = 1'b0;
          ram_addr_d  = iaddr;
          ram_store_d = 32'd0;
        end
      end
      IGNT: begin
        if (!iREN || ram_done) begin
          state_d   = IDLE;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          if (iREN) starve_cnt_d = 4'd0;
        end
      end
      DGNT: begin
        if (!data_req || ram_done) begin
          state_d   = IDLE;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          if (data_req && iREN && (starve_cnt_q != LIMIT))
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        ram_ren_d = 1'b0;
        ram_wen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= 32'd0;
      ram_store_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ram_ren_q    <= ram_ren_d;
      ram_wen_q    <= ram_wen_d;
      ram_addr_q   <= ram_addr_d;
      ram_store_q  <= ram_store_d;
    end
  end

  always_comb begin
    iwait    = iREN && !(i_active && ram_done);
    iload    = (i_active && (ramstate == RAM_ACCESS)) ? ramload : 32'd0;
    dwait    = data_req && !(d_active && ram_done);
    dload    = (d_active && dREN && (ramstate == RAM_ACCESS)) ? ramload : 32'd0;
    memerr   = (i_active || d_active) && (ramstate == RAM_ERROR);
    ramREN   = ram_ren_q;
    ramWEN   = ram_wen_q;
    ramaddr  = ram_addr_q;
    ramstore = ram_store_q;
  end

endmodule
